// File: rtl/refill_responder_pkg.sv
// Shared cache constants: refill FSM encoding, array init pattern and block width.
package refill_responder_pkg;

    localparam int          BLOCK_W   = 64;
    localparam logic [31:0] INIT_BASE = 32'h1000_0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_READ_LO = 3'd2,
        ST_READ_HI = 3'd3,
        ST_RESP    = 3'd4,
        ST_HOLD    = 3'd5
    } refill_state_t;

endpackage

// File: rtl/refill_word_array.sv
// Backing word store: filled with INIT_BASE + i while reset is low, read-only otherwise.
// Two asynchronous read ports return the even word and its odd neighbour.
module refill_word_array
    import refill_responder_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    localparam int AW = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rd_idx,
    output logic [31:0]   rd_lo,
    output logic [31:0]   rd_hi
);

    logic [31:0]   mem_reg [MEM_WORDS];
    logic [AW-1:0] hi_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_reg[i] <= INIT_BASE + 32'(i);
            end
        end
    end

    // Index arithmetic is AW bits wide, so index+1 wraps modulo MEM_WORDS for free.
    assign hi_idx = rd_idx + AW'(1);
    assign rd_lo  = mem_reg[rd_idx];
    assign rd_hi  = mem_reg[hi_idx];

endmodule

// File: rtl/refill_responder.sv
// Instruction-cache refill responder: captures a miss, waits LATENCY cycles, reads two
// words into a 64-bit block, strobes it once, then holds until the miss request drops.
module refill_responder
    import refill_responder_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [31:0]        req_addr,
    output logic [BLOCK_W-1:0] block,
    output logic               block_valid,
    output logic               busy
);

    localparam int AW = $clog2(MEM_WORDS);

    refill_state_t      state_reg, state_next;
    logic [3:0]         cnt_reg, cnt_next;
    logic [28:0]        base_reg, base_next;
    logic [BLOCK_W-1:0] block_reg, block_next;
    logic [AW-1:0]      word_idx;
    logic [31:0]        rd_lo, rd_hi;
    logic               unused_bits;

    // Even word of the block; the modulo wrap falls out of truncating the base.
    assign word_idx = {base_reg[AW-2:0], 1'b0};

    refill_word_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .rd_idx (word_idx),
        .rd_lo  (rd_lo),
        .rd_hi  (rd_hi)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            base_reg  <= 29'd0;
            block_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            base_reg  <= base_next;
            block_reg <= block_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        base_next  = base_reg;
        block_next = block_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    base_next  = req_addr[31:3];
                    cnt_next   = 4'(LATENCY);
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = ST_READ_LO;
                end
            end
            ST_READ_LO: begin
                block_next[31:0] = rd_lo;
                state_next       = ST_READ_HI;
            end
            ST_READ_HI: begin
                block_next[BLOCK_W-1:32] = rd_hi;
                state_next               = ST_RESP;
            end
            ST_RESP: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                // A miss still held high must not start a second refill.
                if (!req_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign block       = block_reg;
    assign block_valid = (state_reg == ST_RESP);
    assign busy        = (state_reg != ST_IDLE);

    // Byte offset and base bits above the array index are intentionally ignored.
    assign unused_bits = ^{req_addr[2:0], base_reg[28:AW-1]};

endmodule

// File: doc/refill_responder.md
REFILL_RESPONDER -- requirements
Module: refill_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning wait cycles (legal range 1..15) between request capture and the first array read.
REQ-002 SHALL have parameter MEM_WORDS, default 256, meaning the number of 32-bit words in the backing array (power of two).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the level-held miss request from the cache.
REQ-006 SHALL have port req_addr, input, 32 bits: the byte address of the missing instruction.
REQ-007 SHALL have port block, output, 64 bits: the registered refill block.
REQ-008 SHALL have port block_valid, output, 1 bit: a one-cycle write strobe to the cache.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 SHALL implement the states IDLE, WAIT, READ_LO, READ_HI, RESP and HOLD.
REQ-011 SHALL, in IDLE with req_valid=1 at a rising edge, capture req_addr[31:3] as the block base, load the wait counter with LATENCY, and enter WAIT.
REQ-012 SHALL, in WAIT, decrement the counter each cycle and enter READ_LO on the edge where the counter reaches 1.
REQ-013 SHALL, in READ_LO, load block[31:0] with the word at index (base*2) mod MEM_WORDS and then enter READ_HI.
REQ-014 SHALL, in READ_HI, load block[63:32] with the word at index (base*2+1) mod MEM_WORDS and then enter RESP.
REQ-015 SHALL, in RESP, drive block_valid=1 for exactly one cycle and then enter HOLD.
REQ-016 SHALL hold block_valid=0 in every state other than RESP.
REQ-017 SHALL enter RESP on the (LATENCY+2)th rising edge after the capture edge.
REQ-018 SHALL, in HOLD, stay while req_valid=1 and return to IDLE on the first edge with req_valid=0, so a still-high miss cannot retrigger.
REQ-019 SHALL ignore req_valid and req_addr in every state except IDLE; changes to req_addr mid-request SHALL NOT affect the block.
REQ-020 SHALL hold block stable from RESP until the next READ_LO.
REQ-021 SHALL wrap out-of-range word indices modulo MEM_WORDS, with no error flagged.
REQ-022 SHALL treat req_addr[2:0] as don't-care, so every address within an 8-byte block returns the same block.
REQ-023 SHALL keep the array read-only in normal operation, with word i holding 32'h1000_0000 + i.

Reset
REQ-024 SHALL, while reset=0, asynchronously force state IDLE, the counter to 0, block to 64'h0, block_valid to 0 and busy to 0.
REQ-025 SHALL, while reset=0, initialise array word i to 32'h1000_0000 + i.
REQ-026 SHALL, on reset asserted mid-request (any non-IDLE state), abort the request with no block_valid pulse.
REQ-027 SHALL, after reset deassertion, accept a new request from IDLE on the next edge.

Structure
REQ-028 SHALL take the state encoding (3 bits), the init base constant 32'h1000_0000 and the block width (64) from the shared cache package also used by the cache and memory models.
REQ-029 SHALL place the backing word array in one sub-module, refill_word_array, with asynchronous read, reset-time init and two read ports (index, index+1); the FSM and wait counter SHALL live in refill_responder.

Verification
REQ-030 SHALL cover basic refill: LATENCY=4, req_valid=1 with req_addr=32'h0000_0010 -> block_valid pulses 6 edges after capture with block=64'h1000_0005_1000_0004.
REQ-031 SHALL cover offset alias: req_addr=32'h0000_0014 -> the same block, 64'h1000_0005_1000_0004.
REQ-032 SHALL cover wrap: MEM_WORDS=256, req_addr=32'h0000_07F8 -> block=64'h1000_00FF_1000_00FE; req_addr=32'h0000_0800 -> block=64'h1000_0001_1000_0000.
REQ-033 SHALL cover held miss: req_valid held at 1 for 20 cycles after the response -> exactly one block_valid pulse and busy=1 throughout; busy falls the edge after req_valid drops.
REQ-034 SHALL cover mid-request reset: reset=0 asserted during WAIT -> block=0, busy=0 and no pulse; a request of 32'h0000_0008 after release -> block=64'h1000_0003_1000_0002.
REQ-035 SHALL cover address change while busy: req_addr switched from 32'h0000_0000 to 32'h0000_0100 in WAIT -> block=64'h1000_0001_1000_0000.
